// File: rtl/spi_flash_arbiter.sv
// Two-master SPI flash bus arbiter: round-robin request/grant, whole-frame ownership, idle gap between owners.
// Optional stuck-owner watchdog enabled by defining SPI_FLASH_ARB_TIMEOUT_EN.
module spi_flash_arbiter #(
  parameter int SS_WIDTH       = 1,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                io_sys_clock,
  input  logic                io_sys_reset,
  input  logic                io_xip_req,
  output logic                io_xip_gnt,
  input  logic [SS_WIDTH-1:0] io_xip_ss,
  input  logic                io_xip_sclk,
  input  logic                io_xip_mosi,
  output logic                io_xip_miso,
  input  logic                io_aux_req,
  output logic                io_aux_gnt,
  input  logic [SS_WIDTH-1:0] io_aux_ss,
  input  logic                io_aux_sclk,
  input  logic                io_aux_mosi,
  output logic                io_aux_miso,
  output logic [SS_WIDTH-1:0] io_spi_ss,
  output logic                io_spi_sclk,
  output logic                io_spi_mosi,
  input  logic                io_spi_miso,
  output logic                io_busy,
  output logic                io_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SS_WIDTH-1:0] SS_IDLE = {SS_WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic                owner_req;
  logic [SS_WIDTH-1:0] owner_ss;
  logic                release_ok;

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  localparam int                HOLD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(TIMEOUT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;
  logic              other_req;
`endif

  always_comb begin
    owner_req = 1'b0;
    owner_ss  = SS_IDLE;
    if (state_q == ST_GRANT0) begin
      owner_req = io_xip_req;
      owner_ss  = io_xip_ss;
    end else if (state_q == ST_GRANT1) begin
      owner_req = io_aux_req;
      owner_ss  = io_aux_ss;
    end
  end

  // The owner keeps the bus until it has both dropped req and closed its chip-select frame.
  assign release_ok = !owner_req && (owner_ss == SS_IDLE);

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  assign other_req = (state_q == ST_GRANT0) ? io_aux_req :
                     (state_q == ST_GRANT1) ? io_xip_req : 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (io_xip_req && io_aux_req) begin
          state_d = last_q ? ST_GRANT0 : ST_GRANT1;
          last_d  = !last_q;
        end else if (io_xip_req) begin
          state_d = ST_GRANT0;
          last_d  = 1'b0;
        end else if (io_aux_req) begin
          state_d = ST_GRANT1;
          last_d  = 1'b1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (release_ok) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
        else if (other_req) begin
          // Forced revoke leaves last_q pointing at the stuck owner, so the waiter wins next.
          if (hold_cnt_q == HOLD_LIMIT) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
            timeout_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge io_sys_clock or negedge io_sys_reset) begin
    if (!io_sys_reset) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      gap_cnt_q <= '0;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Mux select comes only from the state register; GAP/IDLE force idle bus levels.
  always_comb begin
    io_spi_ss   = SS_IDLE;
    io_spi_sclk = 1'b0;
    io_spi_mosi = 1'b0;
    io_xip_gnt  = 1'b0;
    io_aux_gnt  = 1'b0;
    io_xip_miso = 1'b0;
    io_aux_miso = 1'b0;
    unique case (state_q)
      ST_GRANT0: begin
        io_xip_gnt  = 1'b1;
        io_spi_ss   = io_xip_ss;
        io_spi_sclk = io_xip_sclk;
        io_spi_mosi = io_xip_mosi;
        io_xip_miso = io_spi_miso;
      end
      ST_GRANT1: begin
        io_aux_gnt  = 1'b1;
        io_spi_ss   = io_aux_ss;
        io_spi_sclk = io_aux_sclk;
        io_spi_mosi = io_aux_mosi;
        io_aux_miso = io_spi_miso;
      end
      default: ;
    endcase
  end

  assign io_busy = (state_q != ST_IDLE);

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  assign io_timeout = timeout_q;
`else
  assign io_timeout = 1'b0;
`endif

endmodule
